// File: rtl/aqed_pkg.sv
// Shared types and helpers for the A-QED functional-consistency / response-bound checker.
//   - aqed_state_e : checker FSM state (3 bits, exported on state_o for cover properties)
//   - Def*         : default parameter values used by the checker and its timers
//   - sat_inc      : saturating increment for counters up to 64 bits wide
package aqed_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StOrigPend = 3'd1,
        StOrigDone = 3'd2,
        StDupPend  = 3'd3,
        StDone     = 3'd4
    } aqed_state_e;

    localparam int unsigned DefDataW    = 16;
    localparam int unsigned DefCntW     = 16;
    localparam int unsigned DefRbCycles = 64;
    localparam int unsigned DefOutW     = 16;

    // Callers zero-extend into 64 bits and cast the result back to their own width.
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input logic [63:0] max_val);
        return (val == max_val) ? val : val + 64'd1;
    endfunction

endpackage

// File: rtl/aqed_rb_timer.sv
// Response-bound timer for one tracked transaction.
//   clk_i     : clock
//   rst_i     : asynchronous active-high reset
//   enable_i  : RB check enabled (tie low to disable)
//   clear_i   : restart the timer at 0 (transaction captured this cycle)
//   pending_i : the tracked output is still outstanding this cycle
//   expired_o : timer has reached the bound while the output is still pending
module aqed_rb_timer
    import aqed_pkg::*;
#(
    parameter int unsigned CNT_W     = DefCntW,
    parameter int unsigned RB_CYCLES = DefRbCycles
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable_i,
    input  logic clear_i,
    input  logic pending_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] CntMax  = '1;
    localparam logic [CNT_W-1:0] RbLimit = CNT_W'(RB_CYCLES);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && pending_i) begin
            // Saturates rather than wrapping so an expired timer stays expired.
            cnt_d = CNT_W'(sat_inc(64'(cnt_q), 64'(CntMax)));
        end
    end

    assign expired_o = enable_i && pending_i && (cnt_q == RbLimit);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/aqed_fc_rb_checker.sv
// A-QED functional-consistency + response-bound checker for an in-order streaming accelerator.
// Captures a solver-chosen original input and a later duplicate with identical data, then
// compares the two corresponding outputs. Each captured transaction must also produce its
// output within RB_CYCLES (0 disables the bound).
//   clk, reset           : clock, asynchronous active-high reset
//   in_valid, in_data    : DUT input handshake
//   mark_orig, mark_dup  : free inputs choosing the original / duplicate transaction
//   out_valid, out_data  : DUT output handshake
//   qed_done             : both outputs observed (sticky)
//   qed_check            : those outputs were equal (0 while qed_done is 0)
//   rb_fail              : a tracked output missed its response bound (sticky)
//   state_o              : current FSM state
module aqed_fc_rb_checker
    import aqed_pkg::*;
#(
    parameter int unsigned DATA_W    = DefDataW,
    parameter int unsigned CNT_W     = DefCntW,
    parameter int unsigned RB_CYCLES = DefRbCycles,
    parameter int unsigned OUT_W     = DefOutW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              mark_orig,
    input  logic              mark_dup,
    input  logic              out_valid,
    input  logic [OUT_W-1:0]  out_data,
    output logic              qed_done,
    output logic              qed_check,
    output logic              rb_fail,
    output logic [2:0]        state_o
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    aqed_state_e       state_d, state_q;
    logic [CNT_W-1:0]  in_cnt_d, in_cnt_q;
    logic [CNT_W-1:0]  out_cnt_d, out_cnt_q;
    logic [CNT_W-1:0]  orig_idx_d, orig_idx_q;
    logic [CNT_W-1:0]  dup_idx_d, dup_idx_q;
    logic [DATA_W-1:0] orig_data_d, orig_data_q;
    logic [OUT_W-1:0]  orig_out_d, orig_out_q;
    logic              dup_taken_d, dup_taken_q;
    logic              qed_done_d, qed_done_q;
    logic              qed_check_d, qed_check_q;
    logic              rb_fail_d, rb_fail_q;

    logic cap_ok, orig_hit, dup_hit, dup_match, same_beat;
    logic orig_clr, dup_clr, orig_pend, dup_pend, orig_exp, dup_exp;

    // Capture is refused once either counter saturates: indices would no longer be unique.
    assign cap_ok    = (in_cnt_q != CntMax) && (out_cnt_q != CntMax);
    assign orig_hit  = out_valid && (out_cnt_q == orig_idx_q);
    assign dup_hit   = out_valid && (out_cnt_q == dup_idx_q);
    assign dup_match = in_valid && mark_dup && (in_data == orig_data_q) && cap_ok;
    // Zero-latency DUT: the output beat this cycle belongs to the input accepted this cycle.
    assign same_beat = out_valid && (out_cnt_q == in_cnt_q);

    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_valid  ? CNT_W'(sat_inc(64'(in_cnt_q),  64'(CntMax))) : in_cnt_q;
        out_cnt_d   = out_valid ? CNT_W'(sat_inc(64'(out_cnt_q), 64'(CntMax))) : out_cnt_q;
        orig_idx_d  = orig_idx_q;
        dup_idx_d   = dup_idx_q;
        orig_data_d = orig_data_q;
        orig_out_d  = orig_out_q;
        dup_taken_d = dup_taken_q;
        qed_done_d  = qed_done_q;
        qed_check_d = qed_check_q;
        orig_clr    = 1'b0;
        dup_clr     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // mark_dup is not looked at here, so orig wins a same-cycle tie.
                if (in_valid && mark_orig && cap_ok) begin
                    orig_data_d = in_data;
                    orig_idx_d  = in_cnt_q;
                    dup_taken_d = 1'b0;
                    orig_clr    = 1'b1;
                    if (same_beat) begin
                        orig_out_d = out_data;
                        state_d    = StOrigDone;
                    end else begin
                        state_d    = StOrigPend;
                    end
                end
            end
            StOrigPend: begin
                if (dup_match && !dup_taken_q) begin
                    dup_idx_d   = in_cnt_q;
                    dup_taken_d = 1'b1;
                    dup_clr     = 1'b1;
                end
                // A dup output ahead of the orig output cannot happen in order; it is ignored.
                if (orig_hit) begin
                    orig_out_d = out_data;
                    state_d    = (dup_taken_q || dup_match) ? StDupPend : StOrigDone;
                end
            end
            StOrigDone: begin
                if (dup_match) begin
                    dup_idx_d   = in_cnt_q;
                    dup_taken_d = 1'b1;
                    dup_clr     = 1'b1;
                    if (same_beat) begin
                        qed_done_d  = 1'b1;
                        qed_check_d = (out_data == orig_out_q);
                        state_d     = StDone;
                    end else begin
                        state_d     = StDupPend;
                    end
                end
            end
            StDupPend: begin
                if (dup_hit) begin
                    qed_done_d  = 1'b1;
                    qed_check_d = (out_data == orig_out_q);
                    state_d     = StDone;
                end
            end
            StDone: begin
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // An output arriving this cycle is no longer pending.
    assign orig_pend = (state_q == StOrigPend) && !orig_hit;
    assign dup_pend  = ((state_q == StOrigPend) && dup_taken_q) ||
                       ((state_q == StDupPend) && !dup_hit);

    aqed_rb_timer #(
        .CNT_W     (CNT_W),
        .RB_CYCLES (RB_CYCLES)
    ) u_orig_timer (
        .clk_i     (clk),
        .rst_i     (reset),
        .enable_i  (RB_CYCLES != 0),
        .clear_i   (orig_clr),
        .pending_i (orig_pend),
        .expired_o (orig_exp)
    );

    aqed_rb_timer #(
        .CNT_W     (CNT_W),
        .RB_CYCLES (RB_CYCLES)
    ) u_dup_timer (
        .clk_i     (clk),
        .rst_i     (reset),
        .enable_i  (RB_CYCLES != 0),
        .clear_i   (dup_clr),
        .pending_i (dup_pend),
        .expired_o (dup_exp)
    );

    assign rb_fail_d = rb_fail_q || orig_exp || dup_exp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            orig_idx_q  <= '0;
            dup_idx_q   <= '0;
            orig_data_q <= '0;
            orig_out_q  <= '0;
            dup_taken_q <= 1'b0;
            qed_done_q  <= 1'b0;
            qed_check_q <= 1'b0;
            rb_fail_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            orig_idx_q  <= orig_idx_d;
            dup_idx_q   <= dup_idx_d;
            orig_data_q <= orig_data_d;
            orig_out_q  <= orig_out_d;
            dup_taken_q <= dup_taken_d;
            qed_done_q  <= qed_done_d;
            qed_check_q <= qed_check_d;
            rb_fail_q   <= rb_fail_d;
        end
    end

    assign qed_done  = qed_done_q;
    assign qed_check = qed_check_q;
    assign rb_fail   = rb_fail_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_aqed_fc_rb_checker.sv
// Directed bench for aqed_fc_rb_checker. The DUT is built with CNT_W=4 (counters saturate
// at 15) and RB_CYCLES=4 so saturation and the response bound are reachable in short runs.
module tb_aqed_fc_rb_checker;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ORIG_PEND = 3'd1;
    localparam logic [2:0] S_ORIG_DONE = 3'd2;
    localparam logic [2:0] S_DUP_PEND  = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        mark_orig = 1'b0;
    logic        mark_dup = 1'b0;
    logic        out_valid = 1'b0;
    logic [15:0] out_data = '0;
    logic        qed_done, qed_check, rb_fail;
    logic [2:0]  state_o;

    int n_vec  = 0;
    int n_fail = 0;

    aqed_fc_rb_checker #(
        .DATA_W    (16),
        .CNT_W     (4),
        .RB_CYCLES (4),
        .OUT_W     (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .mark_orig (mark_orig),
        .mark_dup  (mark_dup),
        .out_valid (out_valid),
        .out_data  (out_data),
        .qed_done  (qed_done),
        .qed_check (qed_check),
        .rb_fail   (rb_fail),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        in_valid = 0; in_data = '0; mark_orig = 0; mark_dup = 0; out_valid = 0; out_data = '0;
    endtask

    // Leaves the bench 1 time unit after a posedge with reset released.
    task automatic do_reset();
        idle_inputs();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
    endtask

    // One cycle: drive, clock, then sample 1 unit after the edge.
    task automatic step(input logic iv, input logic [15:0] id, input logic mo, input logic md,
                        input logic ov, input logic [15:0] od);
        in_valid = iv; in_data = id; mark_orig = mo; mark_dup = md; out_valid = ov; out_data = od;
        @(posedge clk); #1;
        idle_inputs();
    endtask

    // Identity DUT with fixed latency; input i is presented in cycle i (i < n_in).
    // first_done = cycle whose edge first made qed_done visible, -1 if never.
    task automatic run_stream(input int n_in, input int lat, input int oi, input int di,
                              input logic [15:0] od, input logic [15:0] dd, input int corrupt,
                              output int first_done);
        logic [15:0] data [0:15];
        for (int i = 0; i < 16; i++) begin
            data[i] = (i == oi) ? od : (i == di) ? dd : 16'h1000 + 16'(i);
        end
        first_done = -1;
        for (int c = 0; c < n_in + lat + 2; c++) begin
            in_valid  = (c < n_in);
            in_data   = (c < n_in) ? data[c] : 16'h0;
            mark_orig = (c == oi);
            mark_dup  = (c == di);
            out_valid = (c >= lat) && (c - lat < n_in);
            out_data  = out_valid ? (data[c-lat] ^ ((c - lat == corrupt) ? 16'h1 : 16'h0)) : 16'h0;
            @(posedge clk); #1;
            if (qed_done && first_done < 0) first_done = c;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        #2;
        n_vec++; if (state_o !== S_IDLE) begin n_fail++; $display("FAIL reset_state got %0d want %0d", state_o, S_IDLE); end
        n_vec++; if (qed_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", qed_done); end
        n_vec++; if (qed_check !== 1'b0) begin n_fail++; $display("FAIL reset_check got %b want 0", qed_check); end
        n_vec++; if (rb_fail !== 1'b0) begin n_fail++; $display("FAIL reset_rb got %b want 0", rb_fail); end
        @(posedge clk); #1;
        reset = 0;
    endtask

    // Orig at index 2, dup at index 7, latency 3: dup output in cycle 10, done visible after it.
    task automatic test_match();
        int fd;
        do_reset();
        run_stream(8, 3, 2, 7, 16'h00AB, 16'h00AB, -1, fd);
        n_vec++; if (fd !== 10) begin n_fail++; $display("FAIL match_done_cycle got %0d want 10", fd); end
        n_vec++; if (qed_check !== 1'b1) begin n_fail++; $display("FAIL match_check got %b want 1", qed_check); end
        n_vec++; if (rb_fail !== 1'b0) begin n_fail++; $display("FAIL match_rb got %b want 0", rb_fail); end
        n_vec++; if (state_o !== S_DONE) begin n_fail++; $display("FAIL match_state got %0d want %0d", state_o, S_DONE); end
    endtask

    task automatic test_corrupt();
        int fd;
        do_reset();
        run_stream(8, 3, 2, 7, 16'h00AB, 16'h00AB, 7, fd);
        n_vec++; if (fd !== 10) begin n_fail++; $display("FAIL corrupt_done_cycle got %0d want 10", fd); end
        n_vec++; if (qed_check !== 1'b0) begin n_fail++; $display("FAIL corrupt_check got %b want 0", qed_check); end
        n_vec++; if (state_o !== S_DONE) begin n_fail++; $display("FAIL corrupt_state got %0d want %0d", state_o, S_DONE); end
    endtask

    task automatic test_dup_mismatch();
        int fd;
        do_reset();
        run_stream(8, 3, 2, 7, 16'h00AB, 16'h00AC, -1, fd);
        n_vec++; if (fd !== -1) begin n_fail++; $display("FAIL mismatch_done_cycle got %0d want -1", fd); end
        n_vec++; if (state_o !== S_ORIG_DONE) begin n_fail++; $display("FAIL mismatch_state got %0d want %0d", state_o, S_ORIG_DONE); end
        n_vec++; if (qed_check !== 1'b0) begin n_fail++; $display("FAIL mismatch_check got %b want 0", qed_check); end
    endtask

    // Latency 4: dup at index 2 is accepted while the orig output is still pending.
    task automatic test_dup_in_orig_pend();
        int fd;
        do_reset();
        run_stream(7, 4, 0, 2, 16'h0055, 16'h0055, -1, fd);
        n_vec++; if (fd !== 6) begin n_fail++; $display("FAIL early_dup_done_cycle got %0d want 6", fd); end
        n_vec++; if (qed_check !== 1'b1) begin n_fail++; $display("FAIL early_dup_check got %b want 1", qed_check); end
        n_vec++; if (rb_fail !== 1'b0) begin n_fail++; $display("FAIL early_dup_rb got %b want 0", rb_fail); end
    endtask

    // Orig captured at edge 0; timer is 4 after edge 4, so rb_fail appears after edge 5.
    task automatic test_rb_stall();
        do_reset();
        step(1, 16'h00AB, 1, 0, 0, 16'h0);
        n_vec++; if (state_o !== S_ORIG_PEND) begin n_fail++; $display("FAIL stall_capture got %0d want %0d", state_o, S_ORIG_PEND); end
        for (int k = 1; k <= 8; k++) begin
            step(0, 16'h0, 0, 0, (k == 6), (k == 6) ? 16'h00AB : 16'h0);
            if (k == 4) begin
                n_vec++; if (rb_fail !== 1'b0) begin n_fail++; $display("FAIL stall_rb_k4 got %b want 0", rb_fail); end
            end
            if (k == 5) begin
                n_vec++; if (rb_fail !== 1'b1) begin n_fail++; $display("FAIL stall_rb_k5 got %b want 1", rb_fail); end
            end
        end
        n_vec++; if (rb_fail !== 1'b1) begin n_fail++; $display("FAIL stall_rb_sticky got %b want 1", rb_fail); end
        n_vec++; if (qed_done !== 1'b0) begin n_fail++; $display("FAIL stall_done got %b want 0", qed_done); end
        n_vec++; if (state_o !== S_ORIG_DONE) begin n_fail++; $display("FAIL stall_state got %0d want %0d", state_o, S_ORIG_DONE); end
    endtask

    task automatic test_reset_mid();
        int fd;
        do_reset();
        step(1, 16'h00AB, 1, 0, 1, 16'h00AB);
        step(1, 16'h00AB, 0, 1, 0, 16'h0);
        n_vec++; if (state_o !== S_DUP_PEND) begin n_fail++; $display("FAIL mid_pre_state got %0d want %0d", state_o, S_DUP_PEND); end
        reset = 1;
        #1;
        n_vec++; if (state_o !== S_IDLE) begin n_fail++; $display("FAIL mid_reset_state got %0d want %0d", state_o, S_IDLE); end
        n_vec++; if ({qed_done, qed_check, rb_fail} !== 3'b000) begin n_fail++; $display("FAIL mid_reset_outs got %b want 000", {qed_done, qed_check, rb_fail}); end
        #1;
        reset = 0;
        run_stream(8, 3, 2, 7, 16'h00AB, 16'h00AB, -1, fd);
        n_vec++; if (fd !== 10) begin n_fail++; $display("FAIL mid_rerun_done_cycle got %0d want 10", fd); end
        n_vec++; if (qed_check !== 1'b1) begin n_fail++; $display("FAIL mid_rerun_check got %b want 1", qed_check); end
    endtask

    task automatic test_zero_latency();
        do_reset();
        step(1, 16'h00AB, 1, 1, 1, 16'h00AB);
        n_vec++; if (state_o !== S_ORIG_DONE) begin n_fail++; $display("FAIL zl_state got %0d want %0d", state_o, S_ORIG_DONE); end
        n_vec++; if (qed_done !== 1'b0) begin n_fail++; $display("FAIL zl_done got %b want 0", qed_done); end
        step(1, 16'h00AB, 0, 1, 0, 16'h0);
        n_vec++; if (state_o !== S_DUP_PEND) begin n_fail++; $display("FAIL zl_dup_state got %0d want %0d", state_o, S_DUP_PEND); end
        step(0, 16'h0, 0, 0, 1, 16'h00AB);
        n_vec++; if ({qed_done, qed_check} !== 2'b11) begin n_fail++; $display("FAIL zl_final got %b want 11", {qed_done, qed_check}); end
        n_vec++; if (state_o !== S_DONE) begin n_fail++; $display("FAIL zl_final_state got %0d want %0d", state_o, S_DONE); end
    endtask

    // in_cnt=14 still captures; in_cnt=15 (saturated, CNT_W=4) must not.
    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 14; i++) step(1, 16'h0001, 0, 0, 0, 16'h0);
        step(1, 16'h00AB, 1, 0, 0, 16'h0);
        n_vec++; if (state_o !== S_ORIG_PEND) begin n_fail++; $display("FAIL sat_below got %0d want %0d", state_o, S_ORIG_PEND); end
        do_reset();
        for (int i = 0; i < 15; i++) step(1, 16'h0001, 0, 0, 0, 16'h0);
        step(1, 16'h00AB, 1, 0, 0, 16'h0);
        n_vec++; if (state_o !== S_IDLE) begin n_fail++; $display("FAIL sat_at_max got %0d want %0d", state_o, S_IDLE); end
    endtask

    initial begin
        #1;
        test_reset();
        test_match();
        test_corrupt();
        test_dup_mismatch();
        test_dup_in_orig_pend();
        test_rb_stall();
        test_reset_mid();
        test_zero_latency();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
